cpu_sequencer: RTL

- Synthesizable fetch-decode-execute controller for the 8-bit processor.
- Drives inst_reg (pc/en), the registers block (addr/rd/wr/data_in) and the alu (opcode/A/B).
- Sits downstream of inst_reg and upstream of alu and registers.
- One instruction is executed at a time by a multi-cycle FSM; there is no pipelining.

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/cpu_decode.sv | 51 +++++
 rtl/cpu_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, ALU codes, IR field positions and FSM types for cpu_sequencer
// Contents: OP_* instruction opcodes, ALU_* operation codes, default flag
// register address, IR field positions, FSM state and branch-kind enums.
package cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_INV  = 4'b0101;
  localparam logic [3:0] OP_LOAD = 4'b1000;
  localparam logic [3:0] OP_INC  = 4'b1010;
  localparam logic [3:0] OP_DEC  = 4'b1011;
  localparam logic [3:0] OP_HLT  = 4'b1100;
  localparam logic [3:0] OP_JC   = 4'b1101;
  localparam logic [3:0] OP_JNZ  = 4'b1110;
  localparam logic [3:0] OP_JMP  = 4'b1111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_INV = 3'b101;

  localparam logic [2:0] FLAG_ADDR = 3'd7;

  // Instruction word layout: op[15:12] rd[9:8] rs1[5:4] rs2[1:0] imm[7:0]
  localparam int IR_OP_LSB  = 12;
  localparam int IR_OP_W    = 4;
  localparam int IR_RD_LSB  = 8;
  localparam int IR_RS1_LSB = 4;
  localparam int IR_RS2_LSB = 0;
  localparam int IR_REG_W   = 2;
  localparam int IR_IMM_LSB = 0;
  localparam int IR_IMM_W   = 8;

  typedef enum logic [2:0] {
    FETCH, DECODE, RDA, RDB, EXEC, WB, WBF, HALT
  } state_t;

  typedef enum logic [1:0] {
    BR_NONE, BR_JMP, BR_JNZ, BR_JC
  } br_kind_t;

endpackage

// File: rtl/cpu_decode.sv
// rtl/cpu_decode.sv - combinational opcode classifier for cpu_sequencer
// Ports: op (in, 4-bit opcode); alu_op (ALU operation); is_alu (op runs the
// RDA/RDB/EXEC/WB/WBF path); uses_rs2 (RDB reads rs2); is_unary_imm1 (RDB
// forces B=1); writes_flags (WBF follows WB); is_load; is_halt; is_branch
// and branch_kind (JMP/JNZ/JC).
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [3:0] op,
  output logic [2:0] alu_op,
  output logic       is_alu,
  output logic       uses_rs2,
  output logic       is_unary_imm1,
  output logic       writes_flags,
  output logic       is_load,
  output logic       is_halt,
  output logic       is_branch,
  output br_kind_t   branch_kind
);

  always_comb begin
    alu_op        = ALU_ADD;
    is_alu        = 1'b0;
    uses_rs2      = 1'b0;
    is_unary_imm1 = 1'b0;
    is_load       = 1'b0;
    is_halt       = 1'b0;
    branch_kind   = BR_NONE;
    case (op)
      OP_ADD:  begin alu_op = ALU_ADD; is_alu = 1'b1; uses_rs2 = 1'b1; end
      OP_SUB:  begin alu_op = ALU_SUB; is_alu = 1'b1; uses_rs2 = 1'b1; end
      OP_AND:  begin alu_op = ALU_AND; is_alu = 1'b1; uses_rs2 = 1'b1; end
      OP_OR:   begin alu_op = ALU_OR;  is_alu = 1'b1; uses_rs2 = 1'b1; end
      OP_XOR:  begin alu_op = ALU_XOR; is_alu = 1'b1; uses_rs2 = 1'b1; end
      OP_INV:  begin alu_op = ALU_INV; is_alu = 1'b1; end
      OP_INC:  begin alu_op = ALU_ADD; is_alu = 1'b1; is_unary_imm1 = 1'b1; end
      OP_DEC:  begin alu_op = ALU_SUB; is_alu = 1'b1; is_unary_imm1 = 1'b1; end
      OP_LOAD: is_load = 1'b1;
      OP_HLT:  is_halt = 1'b1;
      OP_JMP:  branch_kind = BR_JMP;
      OP_JNZ:  branch_kind = BR_JNZ;
      OP_JC:   branch_kind = BR_JC;
      default: ;  // remaining opcodes are NOPs
    endcase
  end

  // Only ALU operations update the flag register.
  assign writes_flags = is_alu;
  assign is_branch    = (branch_kind != BR_NONE);

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/execute controller for the 8-bit processor
// Ports: clk, rst (sync, active-high); pc/ir_en -> inst_reg, ir_data <- inst_reg
// (valid the cycle after the fetch); rf_addr/rf_rd/rf_wr/rf_wdata -> registers,
// rf_rdata <- registers (same-cycle); alu_op/alu_a/alu_b -> alu,
// alu_out/alu_cy/alu_zero <- alu; halted high while parked in HALT.
module cpu_sequencer #(
  parameter int         PC_W      = 8,
  parameter int         DATA_W    = 8,
  parameter logic [2:0] FLAG_ADDR = cpu_pkg::FLAG_ADDR,
  parameter int         RESET_PC  = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   pc,
  output logic              ir_en,
  input  logic [15:0]       ir_data,
  output logic [2:0]        rf_addr,
  output logic              rf_rd,
  output logic              rf_wr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_cy,
  input  logic              alu_zero,
  output logic              halted
);
  import cpu_pkg::*;

  // JC jumps only on exactly cy=1, zero=0 in the stored flag byte.
  localparam logic [DATA_W-1:0] JC_TAKEN_FLAGS = {1'b1, {(DATA_W-1){1'b0}}};

  state_t              state, state_nxt;
  logic [15:0]         ir;
  logic [DATA_W-1:0]   result;
  logic                cy_q, zero_q;
  logic [2:0]          rf_addr_q;

  logic [3:0]          dec_op;
  logic [2:0]          dec_alu_op;
  logic                is_alu, uses_rs2, is_unary_imm1, writes_flags;
  logic                is_load, is_halt, is_branch;
  br_kind_t            branch_kind;

  logic [PC_W-1:0]     pc_inc;
  logic [PC_W-1:0]     target_ir;
  logic                br_taken;
  logic                unused_ir_bits;

  // During DECODE the new instruction is only on ir_data; afterwards it lives in ir.
  assign dec_op = (state == DECODE) ? ir_data[IR_OP_LSB +: IR_OP_W] : ir[IR_OP_LSB +: IR_OP_W];

  cpu_decode u_decode (
    .op            (dec_op),
    .alu_op        (dec_alu_op),
    .is_alu        (is_alu),
    .uses_rs2      (uses_rs2),
    .is_unary_imm1 (is_unary_imm1),
    .writes_flags  (writes_flags),
    .is_load       (is_load),
    .is_halt       (is_halt),
    .is_branch     (is_branch),
    .branch_kind   (branch_kind)
  );

  assign pc_inc         = pc + 1'b1;
  assign target_ir      = PC_W'(ir[IR_IMM_LSB +: IR_IMM_W]);
  assign br_taken       = (branch_kind == BR_JNZ) ? (rf_rdata != '0) : (rf_rdata == JC_TAKEN_FLAGS);
  assign halted         = (state == HALT);
  assign unused_ir_bits = ^ir[11:10];

  always_comb begin
    state_nxt = state;
    ir_en     = 1'b0;
    rf_rd     = 1'b0;
    rf_wr     = 1'b0;
    rf_addr   = rf_addr_q;
    rf_wdata  = result;
    case (state)
      FETCH: begin
        ir_en     = 1'b1;
        state_nxt = DECODE;
      end
      DECODE: begin
        if (is_alu || branch_kind == BR_JNZ || branch_kind == BR_JC) state_nxt = RDA;
        else if (is_load) state_nxt = WB;
        else if (is_halt) state_nxt = HALT;
        else              state_nxt = FETCH;
      end
      RDA: begin
        rf_rd = 1'b1;
        if (branch_kind == BR_JC)
          rf_addr = FLAG_ADDR;
        else if (is_unary_imm1 || branch_kind == BR_JNZ)
          rf_addr = {1'b0, ir[IR_RD_LSB +: IR_REG_W]};
        else
          rf_addr = {1'b0, ir[IR_RS1_LSB +: IR_REG_W]};
        state_nxt = is_branch ? FETCH : RDB;
      end
      RDB: begin
        if (uses_rs2) begin
          rf_rd   = 1'b1;
          rf_addr = {1'b0, ir[IR_RS2_LSB +: IR_REG_W]};
        end
        state_nxt = EXEC;
      end
      EXEC: state_nxt = WB;
      WB: begin
        rf_wr     = 1'b1;
        rf_addr   = {1'b0, ir[IR_RD_LSB +: IR_REG_W]};
        rf_wdata  = is_load ? DATA_W'(ir[IR_IMM_LSB +: IR_IMM_W]) : result;
        state_nxt = writes_flags ? WBF : FETCH;
      end
      WBF: begin
        rf_wr     = 1'b1;
        rf_addr   = FLAG_ADDR;
        rf_wdata  = {cy_q, zero_q, {(DATA_W-2){1'b0}}};
        state_nxt = FETCH;
      end
      HALT: state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
    if (rst) begin
      ir_en = 1'b0;
      rf_rd = 1'b0;
      rf_wr = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= PC_W'(RESET_PC);
      ir        <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      result    <= '0;
      cy_q      <= 1'b0;
      zero_q    <= 1'b0;
      rf_addr_q <= '0;
    end else begin
      state     <= state_nxt;
      rf_addr_q <= rf_addr;
      case (state)
        DECODE: begin
          ir <= ir_data;
          if (is_alu) alu_op <= dec_alu_op;
          if (branch_kind == BR_JMP)
            pc <= PC_W'(ir_data[IR_IMM_LSB +: IR_IMM_W]);
          else if (!is_alu && !is_load && !is_halt && !is_branch)
            pc <= pc_inc;
        end
        RDA: begin
          alu_a <= rf_rdata;
          if (is_branch) pc <= br_taken ? target_ir : pc_inc;
        end
        RDB: begin
          if (uses_rs2)           alu_b <= rf_rdata;
          else if (is_unary_imm1) alu_b <= DATA_W'(1);
        end
        EXEC: begin
          result <= alu_out;
          cy_q   <= alu_cy;
          zero_q <= alu_zero;
        end
        WB:  if (!writes_flags) pc <= pc_inc;
        WBF: pc <= pc_inc;
        default: ;
      endcase
    end
  end

endmodule
